// File: rtl/pio_fetch_unit_if.sv
// pio_fetch_unit_if: signal bundle between the PIO fetch stage, the host
// program loader and the SM execute/decode stage.
//   master : the loader/SM side. It drives the wrap window, jump, pc_en and the write/debug-read port.
//   slave  : the fetch unit. It drives pc, instr, instr_pc, instr_valid and data_out.
// Parameters: DATA_W instruction width, ADDR_W PC/memory address width.
interface pio_fetch_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] wrap_bottom;
    logic [ADDR_W-1:0] wrap_top;
    logic [ADDR_W-1:0] jump;
    logic              jump_en;
    logic              pc_en;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] write_addr;
    logic              write_en;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output wrap_bottom, wrap_top, jump, jump_en, pc_en,
        output data_in, write_addr, write_en, read_addr,
        input  pc, instr, instr_pc, instr_valid, data_out
    );

    modport slave (
        input  wrap_bottom, wrap_top, jump, jump_en, pc_en,
        input  data_in, write_addr, write_en, read_addr,
        output pc, instr, instr_pc, instr_valid, data_out
    );
endinterface

// File: rtl/pio_fetch_unit.sv
// pio_fetch_unit: instruction fetch stage for a PIO state machine.
// It contains a flop-based program memory (2**ADDR_W words) and a program counter.
// The PC supports a wrap window and jumps. Fetches are registered and flagged
// by a per-fetch valid strobe.
// Ports:
//   clk  : sole clock. All state updates on posedge.
//   rst  : asynchronous active-low reset. Clears PC, fetch registers and the whole memory.
//   bus  : pio_fetch_unit_if.slave, which carries these signals:
//          wrap_bottom/wrap_top : wrap window. Equality compare on wrap_top.
//          jump/jump_en         : PC load. Also flushes the pending fetch.
//          pc_en                : advance the PC and fetch.
//          pc                   : current PC.
//          instr/instr_pc       : last fetched word and the address it came from.
//          instr_valid          : one-cycle strobe for a new, unflushed fetch.
//          data_in/write_addr/write_en : program write port.
//          read_addr/data_out   : combinational debug read port.
// Build option: define PIO_FETCH_BYPASS_EN to forward a same-cycle write to
// the fetched address straight into instr.
module pio_fetch_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input logic             clk,
    input logic             rst,
    pio_fetch_unit_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              fetch;
    logic [DATA_W-1:0] fetch_word;

    // A jump takes priority over the fetch and flushes it.
    assign fetch = bus.pc_en & ~bus.jump_en;

    always_comb begin
        pc_next = pc;
        if (bus.jump_en) begin
            pc_next = bus.jump;
        end else if (bus.pc_en) begin
            if (pc == bus.wrap_top) begin
                pc_next = bus.wrap_bottom;
            end else begin
                // Natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 roll.
                pc_next = pc + 1'b1;
            end
        end
    end

`ifdef PIO_FETCH_BYPASS_EN
    always_comb begin
        fetch_word = mem[pc];
        if (bus.write_en && (bus.write_addr == pc)) begin
            fetch_word = bus.data_in;
        end
    end
`else
    assign fetch_word = mem[pc];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pc          <= pc_next;
            instr_valid <= fetch;
            if (fetch) begin
                instr    <= fetch_word;
                instr_pc <= pc;
            end
            if (bus.write_en) begin
                mem[bus.write_addr] <= bus.data_in;
            end
        end
    end

    assign bus.pc          = pc;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;
    assign bus.data_out    = mem[bus.read_addr];

endmodule

// File: tb/tb_pio_fetch_unit.sv
// tb_pio_fetch_unit: directed plus randomized checks of pio_fetch_unit.
// A behavioural model of the fetch stage and program memory predicts every
// output cycle by cycle.
module tb_pio_fetch_unit;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic clk;
    logic rst;

    pio_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pio_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference state
    int unsigned m_mem [DEPTH];
    int unsigned m_pc;
    int unsigned m_instr;
    int unsigned m_ipc;
    int unsigned m_iv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_pc = 0; m_instr = 0; m_ipc = 0; m_iv = 0;
    endtask

    // Advance the model and the DUT by one clock and compare all outputs.
    task automatic step(input string tag);
        int unsigned n_pc, n_instr, n_ipc, n_iv, word;
        n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_iv = 0;
        if (bus.pc_en && !bus.jump_en) begin
            word = m_mem[m_pc];
`ifdef PIO_FETCH_BYPASS_EN
            if (bus.write_en && bus.write_addr == m_pc) word = bus.data_in;
`endif
            n_instr = word; n_ipc = m_pc; n_iv = 1;
        end
        if (bus.jump_en) n_pc = bus.jump;
        else if (bus.pc_en) n_pc = (m_pc == bus.wrap_top) ? bus.wrap_bottom : (m_pc + 1) % DEPTH;
        if (bus.write_en) m_mem[bus.write_addr] = bus.data_in;
        m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_iv = n_iv;
        @(posedge clk);
        #1;
        chk({tag, ".pc"},       32'(bus.pc),          m_pc);
        chk({tag, ".instr"},    32'(bus.instr),       m_instr);
        chk({tag, ".instr_pc"}, 32'(bus.instr_pc),    m_ipc);
        chk({tag, ".valid"},    32'(bus.instr_valid), m_iv);
        chk({tag, ".data_out"}, 32'(bus.data_out),    m_mem[bus.read_addr]);
    endtask

    task automatic idle_inputs();
        bus.wrap_bottom = '0; bus.wrap_top = '1; bus.jump = '0;
        bus.jump_en = 1'b0; bus.pc_en = 1'b0; bus.data_in = '0;
        bus.write_addr = '0; bus.write_en = 1'b0; bus.read_addr = '0;
    endtask

    int unsigned seq [8] = '{0, 1, 2, 3, 4, 5, 2, 3};
    int unsigned wrap_seq [4] = '{31, 0, 1, 4};
    logic [15:0] bypass_exp;

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("reset.pc",    32'(bus.pc), 0);
        chk("reset.instr", 32'(bus.instr), 0);
        chk("reset.valid", 32'(bus.instr_valid), 0);
        chk("reset.mem",   32'(bus.data_out), 0);
        @(negedge clk);
        rst = 1'b1;

        // Program load
        for (int i = 0; i < DEPTH; i++) begin
            bus.write_en = 1'b1; bus.write_addr = 5'(i);
            bus.data_in = 16'hA000 + 16'(i); bus.read_addr = 5'(i);
            step("load");
        end
        bus.write_en = 1'b0;

        // Wrap window 2..5
        bus.wrap_bottom = 5'd2; bus.wrap_top = 5'd5; bus.pc_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("wrap25");
            chk("wrap25.seq",   32'(bus.instr_pc), seq[i]);
            chk("wrap25.instr", 32'(bus.instr), 32'h0000A000 + seq[i]);
        end
        step("wrap25"); step("wrap25"); step("wrap25");
        chk("wrap25.at3", 32'(bus.pc), 3);

        // Jump flush
        bus.jump = 5'd20; bus.jump_en = 1'b1;
        step("jump");
        chk("jump.pc",    32'(bus.pc), 20);
        chk("jump.flush", 32'(bus.instr_valid), 0);
        bus.jump_en = 1'b0;
        step("jump_tgt");
        chk("jump_tgt.instr", 32'(bus.instr), 32'hA014);
        chk("jump_tgt.ipc",   32'(bus.instr_pc), 20);
        chk("jump_tgt.valid", 32'(bus.instr_valid), 1);

        // Inverted window: bottom=4, top=1, from pc=30
        bus.jump = 5'd30; bus.jump_en = 1'b1;
        step("inv_jump");
        bus.jump_en = 1'b0; bus.wrap_bottom = 5'd4; bus.wrap_top = 5'd1;
        for (int i = 0; i < 4; i++) begin
            step("inv");
            chk("inv.pc", 32'(bus.pc), wrap_seq[i]);
        end

        // Stall at pc=9
        bus.wrap_bottom = '0; bus.wrap_top = '1;
        bus.jump = 5'd9; bus.jump_en = 1'b1;
        step("stall_jump");
        bus.jump_en = 1'b0;
        step("stall_pre");
        bus.jump_en = 1'b1; bus.jump = 5'd9;
        step("stall_jump2");
        bus.jump_en = 1'b0; bus.pc_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.pc",    32'(bus.pc), 9);
            chk("stall.valid", 32'(bus.instr_valid), 0);
        end
        bus.pc_en = 1'b1;
        step("stall_rel");
        chk("stall_rel.ipc", 32'(bus.instr_pc), 9);

        // Same-cycle write to the fetched address
        bus.jump = 5'd6; bus.jump_en = 1'b1;
        step("wr_jump");
        bus.jump_en = 1'b0; bus.write_en = 1'b1; bus.write_addr = 5'd6;
        bus.data_in = 16'hBEEF; bus.read_addr = 5'd6;
        step("wr_fetch");
`ifdef PIO_FETCH_BYPASS_EN
        bypass_exp = 16'hBEEF;
`else
        bypass_exp = 16'hA006;
`endif
        chk("wr_fetch.instr", 32'(bus.instr), 32'(bypass_exp));
        chk("wr_fetch.rdbk",  32'(bus.data_out), 32'hBEEF);
        bus.write_en = 1'b0;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bus.wrap_bottom = 5'($urandom_range(0, 31));
            bus.wrap_top    = 5'($urandom_range(0, 31));
            bus.jump        = 5'($urandom_range(0, 31));
            bus.jump_en     = ($urandom_range(0, 7) == 0);
            bus.pc_en       = ($urandom_range(0, 3) != 0);
            bus.write_en    = ($urandom_range(0, 1) == 1);
            // Bias writes toward the current PC to exercise forwarding.
            bus.write_addr  = ($urandom_range(0, 3) == 0) ? 5'(m_pc) : 5'($urandom_range(0, 31));
            bus.data_in     = 16'($urandom);
            bus.read_addr   = 5'($urandom_range(0, 31));
            step("rand");
        end

        // Asynchronous reset mid-run with pc=7
        idle_inputs();
        bus.jump = 5'd6; bus.jump_en = 1'b1;
        step("rst_prep");
        bus.jump_en = 1'b0; bus.pc_en = 1'b1;
        step("rst_prep");
        chk("rst_prep.pc", 32'(bus.pc), 7);
        bus.pc_en = 1'b0; bus.read_addr = 5'd6;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst.pc",    32'(bus.pc), 0);
        chk("async_rst.instr", 32'(bus.instr), 0);
        chk("async_rst.ipc",   32'(bus.instr_pc), 0);
        chk("async_rst.valid", 32'(bus.instr_valid), 0);
        chk("async_rst.mem",   32'(bus.data_out), 0);
        bus.write_en = 1'b1; bus.write_addr = 5'd3; bus.data_in = 16'h1234; bus.read_addr = 5'd3;
        @(posedge clk);
        #1;
        chk("rst_write_drop", 32'(bus.data_out), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.write_en = 1'b0;
        step("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
